// File: rtl/default_slave_if.sv
// AXI bundle between the interconnect default port and the default slave.
interface default_slave_if #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    logic [ID_W-1:0]     ARID;
    logic [ADDR_W-1:0]   ARADDR;
    logic [LEN_W-1:0]    ARLEN;
    logic [2:0]          ARSIZE;
    logic [1:0]          ARBURST;
    logic                ARVALID;
    logic                ARREADY;

    logic [ID_W-1:0]     RID;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RLAST;
    logic                RVALID;
    logic                RREADY;

    logic [ID_W-1:0]     AWID;
    logic [ADDR_W-1:0]   AWADDR;
    logic [LEN_W-1:0]    AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic                AWVALID;
    logic                AWREADY;

    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;

    logic [ID_W-1:0]     BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY,
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY,
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );
endinterface

// File: rtl/default_slave.sv
// Default AXI slave: terminates unmapped transactions with DECERR.
// Reads return zero data, writes are discarded. Read and write paths
// are independent FSMs; all outputs decode registered state only.
//
//   state   | meaning
//   RD_ADDR | waiting for AR, ARREADY high
//   RD_DATA | streaming DECERR beats until RLAST handshake
//   WR_ADDR | waiting for AW, AWREADY high
//   WR_DATA | sinking W beats until WLAST handshake (AWLEN ignored)
//   WR_RESP | holding DECERR B response until BREADY
module default_slave #(
    parameter int ID_W  = 8,
    parameter int LEN_W = 4
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    default_slave_if.slave   bus
);
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {RD_ADDR, RD_DATA} rd_state_e;
    typedef enum logic [1:0] {WR_ADDR, WR_DATA, WR_RESP} wr_state_e;

    rd_state_e        rd_state_q, rd_state_d;
    logic [ID_W-1:0]  rid_q, rid_d;
    logic [LEN_W-1:0] rlen_q, rlen_d;
    logic [LEN_W-1:0] rcnt_q, rcnt_d;

    wr_state_e        wr_state_q, wr_state_d;
    logic [ID_W-1:0]  bid_q, bid_d;

    logic             rlast;

    // Fields that an error responder has no use for.
    logic unused_inputs;
    assign unused_inputs = ^{bus.ARADDR, bus.ARSIZE, bus.ARBURST,
                             bus.AWADDR, bus.AWLEN, bus.AWSIZE, bus.AWBURST,
                             bus.WDATA, bus.WSTRB};

    assign rlast = (rd_state_q == RD_DATA) && (rcnt_q == rlen_q);

    // Read path state register; reset aborts any burst in flight.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rd_state_q <= RD_ADDR;
            rid_q      <= '0;
            rlen_q     <= '0;
            rcnt_q     <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rid_q      <= rid_d;
            rlen_q     <= rlen_d;
            rcnt_q     <= rcnt_d;
        end
    end

    // Read next-state and output decode.
    always_comb begin
        rd_state_d  = rd_state_q;
        rid_d       = rid_q;
        rlen_d      = rlen_q;
        rcnt_d      = rcnt_q;
        bus.ARREADY = 1'b0;
        bus.RVALID  = 1'b0;
        bus.RID     = rid_q;
        bus.RDATA   = '0;
        bus.RRESP   = 2'b00;
        bus.RLAST   = 1'b0;
        case (rd_state_q)
            RD_ADDR: begin
                bus.ARREADY = 1'b1;
                if (bus.ARVALID) begin
                    rid_d      = bus.ARID;
                    rlen_d     = bus.ARLEN;
                    rcnt_d     = '0;
                    rd_state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                bus.RVALID = 1'b1;
                bus.RRESP  = RESP_DECERR;
                bus.RLAST  = rlast;
                if (bus.RREADY) begin
                    if (rlast) rd_state_d = RD_ADDR;
                    else       rcnt_d     = rcnt_q + LEN_W'(1);
                end
            end
            default: rd_state_d = RD_ADDR;
        endcase
    end

    // Write path state register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_state_q <= WR_ADDR;
            bid_q      <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            bid_q      <= bid_d;
        end
    end

    // Write next-state and output decode; WLAST alone ends the burst.
    always_comb begin
        wr_state_d  = wr_state_q;
        bid_d       = bid_q;
        bus.AWREADY = 1'b0;
        bus.WREADY  = 1'b0;
        bus.BVALID  = 1'b0;
        bus.BID     = bid_q;
        bus.BRESP   = 2'b00;
        case (wr_state_q)
            WR_ADDR: begin
                bus.AWREADY = 1'b1;
                if (bus.AWVALID) begin
                    bid_d      = bus.AWID;
                    wr_state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                bus.WREADY = 1'b1;
                if (bus.WVALID && bus.WLAST) wr_state_d = WR_RESP;
            end
            WR_RESP: begin
                bus.BVALID = 1'b1;
                bus.BRESP  = RESP_DECERR;
                if (bus.BREADY) wr_state_d = WR_ADDR;
            end
            default: wr_state_d = WR_ADDR;
        endcase
    end
endmodule

// File: tb/tb_default_slave.sv
// Directed bench for default_slave.
module tb_default_slave;
    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    default_slave_if #(.ID_W(8), .ADDR_W(32), .DATA_W(32), .LEN_W(4)) bus ();

    default_slave #(.ID_W(8), .LEN_W(4)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ARID = '0; bus.ARADDR = 32'hdead_0000; bus.ARLEN = '0;
        bus.ARSIZE = 3'd2; bus.ARBURST = 2'b01; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b0;
        bus.AWID = '0; bus.AWADDR = 32'hbeef_0000; bus.AWLEN = '0;
        bus.AWSIZE = 3'd2; bus.AWBURST = 2'b01; bus.AWVALID = 1'b0;
        bus.WDATA = 32'h1234_5678; bus.WSTRB = 4'hf; bus.WLAST = 1'b0;
        bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        ARESETn = 1'b0;
        #2;
        checks++; if (bus.ARREADY !== 1'b1) begin errors++; $display("FAIL reset_arready got %b exp 1", bus.ARREADY); end
        checks++; if (bus.AWREADY !== 1'b1) begin errors++; $display("FAIL reset_awready got %b exp 1", bus.AWREADY); end
        checks++; if ({bus.RVALID, bus.WREADY, bus.BVALID, bus.RLAST} !== 4'b0000) begin errors++; $display("FAIL reset_valids got %b exp 0000", {bus.RVALID, bus.WREADY, bus.BVALID, bus.RLAST}); end
        checks++; if ({bus.RID, bus.BID, bus.RDATA, bus.RRESP, bus.BRESP} !== 52'd0) begin errors++; $display("FAIL reset_fields got %h exp 0", {bus.RID, bus.BID, bus.RDATA, bus.RRESP, bus.BRESP}); end
        tick();
        ARESETn = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        bus.ARID = 8'h13; bus.ARLEN = 4'd0; bus.ARVALID = 1'b1;
        tick();
        bus.ARVALID = 1'b0;
        checks++; if (bus.RVALID !== 1'b1) begin errors++; $display("FAIL single_rvalid got %b exp 1", bus.RVALID); end
        checks++; if (bus.RID !== 8'h13) begin errors++; $display("FAIL single_rid got %h exp 13", bus.RID); end
        checks++; if (bus.RDATA !== 32'h0) begin errors++; $display("FAIL single_rdata got %h exp 0", bus.RDATA); end
        checks++; if (bus.RRESP !== 2'b11) begin errors++; $display("FAIL single_rresp got %b exp 11", bus.RRESP); end
        checks++; if (bus.RLAST !== 1'b1) begin errors++; $display("FAIL single_rlast got %b exp 1", bus.RLAST); end
        checks++; if (bus.ARREADY !== 1'b0) begin errors++; $display("FAIL single_arready_busy got %b exp 0", bus.ARREADY); end
        bus.RREADY = 1'b1;
        tick();
        bus.RREADY = 1'b0;
        checks++; if (bus.RVALID !== 1'b0) begin errors++; $display("FAIL single_rvalid_done got %b exp 0", bus.RVALID); end
        checks++; if (bus.ARREADY !== 1'b1) begin errors++; $display("FAIL single_arready_back got %b exp 1", bus.ARREADY); end
    endtask

    task automatic test_burst16();
        int beats = 0;
        bus.ARID = 8'h5a; bus.ARLEN = 4'd15; bus.ARVALID = 1'b1;
        tick();
        bus.ARVALID = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.RVALID !== 1'b1) break;
            checks++; if (bus.RID !== 8'h5a) begin errors++; $display("FAIL burst_rid beat %0d got %h exp 5a", beats, bus.RID); end
            checks++; if (bus.RRESP !== 2'b11 || bus.RDATA !== 32'h0) begin errors++; $display("FAIL burst_resp beat %0d got %b/%h exp 11/0", beats, bus.RRESP, bus.RDATA); end
            checks++; if (bus.RLAST !== (beats == 15)) begin errors++; $display("FAIL burst_rlast beat %0d got %b exp %b", beats, bus.RLAST, beats == 15); end
            bus.RREADY = ((c % 2) == 0);
            tick();
            if (bus.RREADY) beats++;
        end
        bus.RREADY = 1'b0;
        checks++; if (beats !== 16) begin errors++; $display("FAIL burst_beats got %0d exp 16", beats); end
        checks++; if (bus.ARREADY !== 1'b1 || bus.RVALID !== 1'b0) begin errors++; $display("FAIL burst_end got arready %b rvalid %b exp 1 0", bus.ARREADY, bus.RVALID); end
    endtask

    task automatic test_write();
        bus.AWID = 8'h21; bus.AWLEN = 4'd3; bus.AWVALID = 1'b1;
        bus.WVALID = 1'b1; bus.WLAST = 1'b0;
        #1;
        checks++; if (bus.WREADY !== 1'b0) begin errors++; $display("FAIL write_w_stall got %b exp 0", bus.WREADY); end
        tick();
        bus.AWVALID = 1'b0;
        checks++; if (bus.AWREADY !== 1'b0) begin errors++; $display("FAIL write_awready_busy got %b exp 0", bus.AWREADY); end
        for (int i = 0; i < 4; i++) begin
            bus.WLAST = (i == 3);
            checks++; if (bus.WREADY !== 1'b1 || bus.BVALID !== 1'b0) begin errors++; $display("FAIL write_beat %0d got wready %b bvalid %b exp 1 0", i, bus.WREADY, bus.BVALID); end
            tick();
        end
        bus.WVALID = 1'b0; bus.WLAST = 1'b0;
        checks++; if (bus.BVALID !== 1'b1 || bus.BID !== 8'h21 || bus.BRESP !== 2'b11) begin errors++; $display("FAIL write_b got %b %h %b exp 1 21 11", bus.BVALID, bus.BID, bus.BRESP); end
        checks++; if (bus.WREADY !== 1'b0) begin errors++; $display("FAIL write_wready_resp got %b exp 0", bus.WREADY); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.BVALID !== 1'b1 || bus.BID !== 8'h21) begin errors++; $display("FAIL write_b_hold cycle %0d got %b %h exp 1 21", i, bus.BVALID, bus.BID); end
        end
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0;
        checks++; if (bus.BVALID !== 1'b0 || bus.AWREADY !== 1'b1) begin errors++; $display("FAIL write_done got bvalid %b awready %b exp 0 1", bus.BVALID, bus.AWREADY); end
    endtask

    task automatic test_mismatch();
        bus.AWID = 8'h33; bus.AWLEN = 4'd7; bus.AWVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        bus.WVALID = 1'b1; bus.WLAST = 1'b0;
        tick();
        bus.WLAST = 1'b1;
        tick();
        bus.WVALID = 1'b0; bus.WLAST = 1'b0;
        checks++; if (bus.BVALID !== 1'b1 || bus.BID !== 8'h33) begin errors++; $display("FAIL mismatch_b got %b %h exp 1 33", bus.BVALID, bus.BID); end
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0;
        checks++; if (bus.AWREADY !== 1'b1) begin errors++; $display("FAIL mismatch_awready got %b exp 1", bus.AWREADY); end
        bus.AWID = 8'h44; bus.AWLEN = 4'd0; bus.AWVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        checks++; if (bus.WREADY !== 1'b1 || bus.AWREADY !== 1'b0) begin errors++; $display("FAIL mismatch_next_aw got wready %b awready %b exp 1 0", bus.WREADY, bus.AWREADY); end
        bus.WVALID = 1'b1; bus.WLAST = 1'b1; bus.BREADY = 1'b1;
        tick();
        bus.WVALID = 1'b0; bus.WLAST = 1'b0;
        checks++; if (bus.BVALID !== 1'b1 || bus.BID !== 8'h44) begin errors++; $display("FAIL mismatch_next_b got %b %h exp 1 44", bus.BVALID, bus.BID); end
        tick();
        bus.BREADY = 1'b0;
    endtask

    task automatic test_concurrent();
        int rbeats = 0;
        int bcount = 0;
        int cycles = 0;
        bus.ARID = 8'h61; bus.ARLEN = 4'd2; bus.ARVALID = 1'b1;
        bus.AWID = 8'h62; bus.AWLEN = 4'd0; bus.AWVALID = 1'b1;
        bus.RREADY = 1'b1; bus.BREADY = 1'b1; bus.WVALID = 1'b1; bus.WLAST = 1'b1;
        tick();
        bus.ARVALID = 1'b0; bus.AWVALID = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cycles++;
            if (bus.RVALID === 1'b1) begin
                checks++; if (bus.RID !== 8'h61 || bus.RLAST !== (rbeats == 2)) begin errors++; $display("FAIL conc_r beat %0d got %h %b exp 61 %b", rbeats, bus.RID, bus.RLAST, rbeats == 2); end
                rbeats++;
            end
            if (bus.BVALID === 1'b1) begin
                checks++; if (bus.BID !== 8'h62 || bus.BRESP !== 2'b11) begin errors++; $display("FAIL conc_b got %h %b exp 62 11", bus.BID, bus.BRESP); end
                bcount++;
            end
            if (bus.WREADY === 1'b1) begin
                checks++; if (c !== 0) begin errors++; $display("FAIL conc_w_cycle got %0d exp 0", c); end
            end
            tick();
            if (bus.ARREADY === 1'b1 && bus.AWREADY === 1'b1) break;
        end
        bus.RREADY = 1'b0; bus.BREADY = 1'b0; bus.WVALID = 1'b0; bus.WLAST = 1'b0;
        checks++; if (rbeats !== 3 || bcount !== 1) begin errors++; $display("FAIL conc_counts got r %0d b %0d exp 3 1", rbeats, bcount); end
        checks++; if (cycles !== 3) begin errors++; $display("FAIL conc_cycles got %0d exp 3", cycles); end
    endtask

    task automatic test_reset_mid();
        bus.ARID = 8'h70; bus.ARLEN = 4'd4; bus.ARVALID = 1'b1;
        tick();
        bus.ARVALID = 1'b0;
        bus.RREADY = 1'b1;
        tick();
        tick();
        checks++; if (bus.RVALID !== 1'b1 || bus.RLAST !== 1'b0 || bus.RID !== 8'h70) begin errors++; $display("FAIL rstmid_beat3 got %b %b %h exp 1 0 70", bus.RVALID, bus.RLAST, bus.RID); end
        ARESETn = 1'b0;
        #1;
        checks++; if (bus.RVALID !== 1'b0 || bus.ARREADY !== 1'b1) begin errors++; $display("FAIL rstmid_abort got rvalid %b arready %b exp 0 1", bus.RVALID, bus.ARREADY); end
        ARESETn = 1'b1;
        tick();
        checks++; if (bus.RVALID !== 1'b0) begin errors++; $display("FAIL rstmid_no_partial got %b exp 0", bus.RVALID); end
        bus.ARID = 8'h71; bus.ARLEN = 4'd1; bus.ARVALID = 1'b1;
        tick();
        bus.ARVALID = 1'b0;
        checks++; if (bus.RVALID !== 1'b1 || bus.RID !== 8'h71 || bus.RLAST !== 1'b0) begin errors++; $display("FAIL rstmid_new0 got %b %h %b exp 1 71 0", bus.RVALID, bus.RID, bus.RLAST); end
        tick();
        checks++; if (bus.RVALID !== 1'b1 || bus.RID !== 8'h71 || bus.RLAST !== 1'b1) begin errors++; $display("FAIL rstmid_new1 got %b %h %b exp 1 71 1", bus.RVALID, bus.RID, bus.RLAST); end
        tick();
        bus.RREADY = 1'b0;
        checks++; if (bus.RVALID !== 1'b0 || bus.ARREADY !== 1'b1) begin errors++; $display("FAIL rstmid_done got %b %b exp 0 1", bus.RVALID, bus.ARREADY); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_burst16();
        test_write();
        test_mismatch();
        test_concurrent();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
